// File: rtl/isqrt_result_reorder_if.sv
// ---------------------------------------------------------------------------
// isqrt_result_reorder_if
// Bundles the distributor-facing and worker-facing signals of the isqrt
// result reorder buffer.
//   alloc_req / alloc_rdy / alloc_tag : tag allocation handshake
//   in_vld / in_tag / in_data         : tagged worker result return
//   res_vld / res                     : in-order result stream
//   count / err                       : occupancy and sticky protocol error
// Modports:
//   master : the environment side (distributor, workers, result sink)
//   slave  : the reorder buffer itself
// ---------------------------------------------------------------------------
interface isqrt_result_reorder_if #(
    parameter int n_tags = 8,
    parameter int width  = 32
);
    localparam int tag_w = $clog2(n_tags);

    logic              alloc_req;
    logic              alloc_rdy;
    logic [tag_w-1:0]  alloc_tag;
    logic              in_vld;
    logic [tag_w-1:0]  in_tag;
    logic [width-1:0]  in_data;
    logic              res_vld;
    logic [width-1:0]  res;
    logic [tag_w:0]    count;
    logic              err;

    modport master (
        output alloc_req, in_vld, in_tag, in_data,
        input  alloc_rdy, alloc_tag, res_vld, res, count, err
    );

    modport slave (
        input  alloc_req, in_vld, in_tag, in_data,
        output alloc_rdy, alloc_tag, res_vld, res, count, err
    );
endinterface

// File: rtl/isqrt_result_reorder.sv
// ---------------------------------------------------------------------------
// isqrt_result_reorder
// Hands out sequence tags to issued isqrt arguments, buffers the tagged
// results that come back from workers in any order, and emits them strictly
// in issue order, at most one per cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, discards everything outstanding
//   bus   : isqrt_result_reorder_if.slave (alloc, return, result, status)
// ---------------------------------------------------------------------------
module isqrt_result_reorder #(
    parameter  int n_tags = 8,
    parameter  int width  = 32,
    localparam int tag_w  = $clog2(n_tags)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    isqrt_result_reorder_if.slave   bus
);
    localparam logic [tag_w:0] CNT_FULL = (tag_w + 1)'(n_tags);

    logic [tag_w-1:0]  wr_ptr_q, wr_ptr_d;
    logic [tag_w-1:0]  rd_ptr_q, rd_ptr_d;
    logic [tag_w:0]    count_q,  count_d;
    logic              err_q,    err_d;
    logic [n_tags-1:0] vld_q;
    logic [n_tags-1:0] busy_q;
    logic [width-1:0]  data_q [n_tags];
    logic [width-1:0]  res_q;
    logic              res_vld_q;

    logic alloc_rdy;
    logic alloc_fire;
    logic retire;
    logic ret_ok;
    logic ret_bad;
    logic alloc_bad;

    // Ready depends on registered occupancy only, so an alloc can never
    // claim the slot that is being freed on the same edge.
    assign alloc_rdy  = (count_q != CNT_FULL);
    assign alloc_fire = bus.alloc_req && alloc_rdy;
    assign alloc_bad  = bus.alloc_req && !alloc_rdy;
    assign retire     = vld_q[rd_ptr_q];

    // A return is accepted only into an allocated, still-empty entry.
    assign ret_ok     = bus.in_vld && busy_q[bus.in_tag] && !vld_q[bus.in_tag];
    assign ret_bad    = bus.in_vld && !ret_ok;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | ret_bad | alloc_bad;

        if (alloc_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (retire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (alloc_fire && !retire) begin
            count_d = count_q + 1'b1;
        end else if (!alloc_fire && retire) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            res_vld_q <= 1'b0;
            res_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            res_vld_q <= retire;
            if (retire) begin
                res_q <= data_q[rd_ptr_q];
            end
        end
    end

    // Per-entry allocation and full flags. Alloc and retire never target
    // the same entry on one edge (the pointers only coincide when the
    // buffer is empty or full), and a return can never hit the retiring
    // entry because that entry is already full.
    genvar gi;
    generate
        for (gi = 0; gi < n_tags; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    busy_q[gi] <= 1'b0;
                    vld_q[gi]  <= 1'b0;
                end else begin
                    if (alloc_fire && (wr_ptr_q == tag_w'(gi))) begin
                        busy_q[gi] <= 1'b1;
                    end else if (retire && (rd_ptr_q == tag_w'(gi))) begin
                        busy_q[gi] <= 1'b0;
                    end

                    if (ret_ok && (bus.in_tag == tag_w'(gi))) begin
                        vld_q[gi] <= 1'b1;
                    end else if (retire && (rd_ptr_q == tag_w'(gi))) begin
                        vld_q[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // Payload storage: one write port, one registered read at rd_ptr.
    // Not reset; an entry is only ever read after a legal return wrote it.
    always_ff @(posedge clk) begin
        if (ret_ok) begin
            data_q[bus.in_tag] <= bus.in_data;
        end
    end

    assign bus.alloc_rdy = alloc_rdy;
    assign bus.alloc_tag = wr_ptr_q;
    assign bus.res_vld   = res_vld_q;
    assign bus.res       = res_q;
    assign bus.count     = count_q;
    assign bus.err       = err_q;
endmodule
